// File: rtl/aes_pkg.sv
// Shared types and constants for the AES serial loader: FSM encoding,
// block width and key-width helper.
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        GAP,
        KEY,
        DONE
    } state_t;

    localparam int BLOCK_W = 128;
    localparam int CNT_W   = 8;

    function automatic int key_width(input int nk);
        return 32 * nk;
    endfunction

endpackage

// File: rtl/aes_piso_shift.sv
// Parallel-load shift register, MSB out / LSB in. Doubles as the echo
// capture: after W shifts it holds whatever arrived on si.
module aes_piso_shift #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    input  logic         si,
    output logic [W-1:0] q,
    output logic         so
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        q <= '0;
        else if (load)  q <= din;
        else if (shift) q <= {q[W-2:0], si};
    end

    // Bit that sits at the serial output once this edge has taken effect,
    // so the caller can register it without a cycle of lag.
    assign so = load ? din[W-1] : (shift ? q[W-2] : q[W-1]);

endmodule

// File: rtl/aes_serial_loader.sv
// Streams a 128-bit block then the key into a serial AES core, MSB first,
// while capturing the core's previous register contents from its echo lines.
module aes_serial_loader
    import aes_pkg::*;
#(
    parameter int NK = 6,
    localparam int KEY_W = key_width(NK)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BLOCK_W-1:0] data_in,
    input  logic [KEY_W-1:0]   key_in,
    output logic               busy,
    output logic               load_done,
    output logic               cs1,
    output logic               cs2,
    output logic               mosi,
    input  logic               misod,
    input  logic               misok,
    output logic [BLOCK_W-1:0] data_echo,
    output logic [KEY_W-1:0]   key_echo
);

    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(BLOCK_W - 1);
    localparam logic [CNT_W-1:0] KEY_LAST  = CNT_W'(KEY_W - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             d_so;
    logic             k_so;

    assign accept = (state == IDLE) && start;

    aes_piso_shift #(.W(BLOCK_W)) u_data (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (state == DATA),
        .din   (data_in),
        .si    (misod),
        .q     (data_echo),
        .so    (d_so)
    );

    aes_piso_shift #(.W(KEY_W)) u_key (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (state == KEY),
        .din   (key_in),
        .si    (misok),
        .q     (key_echo),
        .so    (k_so)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            load_done <= 1'b0;
            cs1       <= 1'b1;
            cs2       <= 1'b1;
            mosi      <= 1'b0;
        end else begin
            load_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= DATA;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        cs1   <= 1'b0;
                        mosi  <= d_so;
                    end
                end
                DATA: begin
                    if (cnt == DATA_LAST) begin
                        state <= GAP;
                        cnt   <= '0;
                        cs1   <= 1'b1;
                        mosi  <= k_so;
                    end else begin
                        cnt  <= cnt + 1'b1;
                        mosi <= d_so;
                    end
                end
                // One dead cycle with both selects high between phases.
                GAP: begin
                    state <= KEY;
                    cnt   <= '0;
                    cs2   <= 1'b0;
                    mosi  <= k_so;
                end
                KEY: begin
                    if (cnt == KEY_LAST) begin
                        state     <= DONE;
                        cnt       <= '0;
                        cs2       <= 1'b1;
                        load_done <= 1'b1;
                        mosi      <= 1'b0;
                    end else begin
                        cnt  <= cnt + 1'b1;
                        mosi <= k_so;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                    cs1   <= 1'b1;
                    cs2   <= 1'b1;
                    mosi  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_serial_loader.sv
// Scoreboard bench: NK=4/6/8 loaders share stimulus; each has a core echo
// model and a monitor that checks the captured stream at every load_done.
module tb_aes_serial_loader;

    typedef struct {
        logic [127:0] d;
        logic [255:0] k;
        logic [127:0] ed;
        logic [255:0] ek;
    } exp_t;

    localparam logic [255:0] PRE_K256 = {32{8'ha5}};

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] data_in;
    logic [255:0] key_in;

    logic [2:0]   busy, load_done, cs1, cs2, mosi;
    logic [127:0] decho [3];
    logic [255:0] kecho [3];

    logic [127:0] push_d;
    logic [255:0] push_k;
    event         ev_push, ev_clr, ev_end;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int NKG = 4 + 2 * g;
        localparam int KW  = 32 * NKG;
        localparam logic [KW-1:0] PRE_K = {(NKG * 4){8'ha5}};

        logic [KW-1:0]  ke;
        logic [127:0]   core_d;
        logic [KW-1:0]  core_k;
        exp_t           q[$];
        logic [127:0]   pd = '1;
        logic [255:0]   pk = PRE_K256 >> (256 - KW);

        aes_serial_loader #(.NK(NKG)) dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start),
            .data_in   (data_in),
            .key_in    (key_in[255 -: KW]),
            .busy      (busy[g]),
            .load_done (load_done[g]),
            .cs1       (cs1[g]),
            .cs2       (cs2[g]),
            .mosi      (mosi[g]),
            .misod     (core_d[127]),
            .misok     (core_k[KW-1]),
            .data_echo (decho[g]),
            .key_echo  (ke)
        );
        assign kecho[g] = 256'(ke);

        // Core model: shifts its register out MSB first while selected.
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                core_d <= '1;
                core_k <= PRE_K;
            end else begin
                if (!cs1[g]) core_d <= {core_d[126:0], mosi[g]};
                if (!cs2[g]) core_k <= {core_k[KW-2:0], mosi[g]};
            end
        end

        always @(ev_push) begin
            exp_t e;
            e.d  = push_d;
            e.k  = push_k >> (256 - KW);
            e.ed = pd;
            e.ek = pk;
            q.push_back(e);
            pd = e.d;
            pk = e.k;
        end

        always @(ev_clr) begin
            q.delete();
            pd = '1;
            pk = PRE_K256 >> (256 - KW);
        end

        always @(ev_end) chk($sformatf("nk%0d_pending", NKG), 256'(q.size()), 256'd0);

        int           cyc, nd, nk, ngap;
        logic [127:0] ds;
        logic [255:0] ks;
        logic         ovl, gbit;
        logic         inl = 1'b0;

        always @(negedge clk) begin
            if (rst) begin
                inl = 1'b0;
            end else begin
                if (busy[g] && !inl) begin
                    inl = 1'b1; cyc = 0; nd = 0; nk = 0; ngap = 0;
                    ds = '0; ks = '0; ovl = 1'b0; gbit = 1'b0;
                end
                if (inl) begin
                    cyc++;
                    if (!cs1[g]) begin ds = {ds[126:0], mosi[g]}; nd++; end
                    if (!cs2[g]) begin ks = {ks[254:0], mosi[g]}; nk++; end
                    if (!cs1[g] && !cs2[g]) ovl = 1'b1;
                    if (busy[g] && cs1[g] && cs2[g] && !load_done[g]) begin
                        ngap++;
                        gbit = mosi[g];
                    end
                end
                if (load_done[g]) begin
                    if (q.size() == 0) begin
                        chk($sformatf("nk%0d_spurious_done", NKG), 256'd1, 256'd0);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk($sformatf("nk%0d_latency", NKG), 256'(cyc), 256'(130 + KW));
                        chk($sformatf("nk%0d_data_stream", NKG), 256'(ds), 256'(e.d));
                        chk($sformatf("nk%0d_key_stream", NKG), ks, e.k);
                        chk($sformatf("nk%0d_cs1_cycles", NKG), 256'(nd), 256'd128);
                        chk($sformatf("nk%0d_cs2_cycles", NKG), 256'(nk), 256'(KW));
                        chk($sformatf("nk%0d_gap_cycles", NKG), 256'(ngap), 256'd1);
                        chk($sformatf("nk%0d_gap_mosi", NKG), 256'(gbit), 256'(e.k[KW-1]));
                        chk($sformatf("nk%0d_cs_overlap", NKG), 256'(ovl), 256'd0);
                        chk($sformatf("nk%0d_data_echo", NKG), 256'(decho[g]), 256'(e.ed));
                        chk($sformatf("nk%0d_key_echo", NKG), kecho[g], e.ek);
                    end
                    inl = 1'b0;
                end
            end
        end
    end

    task automatic push(input logic [127:0] d, input logic [255:0] k);
        push_d = d;
        push_k = k;
        -> ev_push;
        #1;
    endtask

    task automatic pulse(input logic [127:0] d, input logic [255:0] k);
        @(negedge clk);
        data_in = d;
        key_in  = k;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy !== 3'b000 && n < 1000) begin
            @(posedge clk);
            #1 n++;
        end
        chk({nm, "_idle_wait"}, 256'(busy), 256'd0);
        repeat (2) @(posedge clk);
    endtask

    localparam logic [127:0] D1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] K1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] D2 = 128'hfedcba98765432100f1e2d3c4b5a6978;
    localparam logic [255:0] K2 = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] D3 = 128'hdeadbeefcafef00d0123456789abcdef;
    localparam logic [255:0] K3 = 256'hc0ffee00112233445566778899aabbccddeeff0011223344556677889900aabb;
    localparam logic [127:0] D4 = 128'h55555555aaaaaaaa33333333cccccccc;
    localparam logic [255:0] K4 = 256'h0f0f0f0ff0f0f0f01234567812345678876543218765432100ff00ff00ff00ff;
    localparam logic [127:0] D5 = 128'h80000000000000000000000000000001;
    localparam logic [255:0] K5 = 256'h8000000000000000000000000000000000000000000000000000000000000001;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int ndone;
        rst = 1'b1; start = 1'b0; data_in = '0; key_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 256'(busy), 256'd0);
        chk("rst_load_done", 256'(load_done), 256'd0);
        chk("rst_cs1", 256'(cs1), 256'd7);
        chk("rst_cs2", 256'(cs2), 256'd7);
        chk("rst_mosi", 256'(mosi), 256'd0);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("rst_data_echo%0d", g), 256'(decho[g]), 256'd0);
            chk($sformatf("rst_key_echo%0d", g), kecho[g], 256'd0);
        end
        @(negedge clk) rst = 1'b0;

        // Reference vectors; echoes come back from the preloaded core.
        push(D1, K1);
        pulse(D1, K1);
        wait_idle("a");

        // Mid-load start and input changes must be ignored.
        push(D2, K2);
        pulse(D2, K2);
        repeat (10) @(posedge clk);
        #1;
        data_in = ~D2;
        key_in  = ~K2;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle("b");

        // start held high: one load, then a second right after DONE.
        push(D3, K3);
        push(D3, K3);
        @(negedge clk);
        data_in = D3; key_in = K3; start = 1'b1;
        repeat (400) @(posedge clk);
        #1 start = 1'b0;
        wait_idle("c");

        // Reset during the key phase aborts without load_done.
        push(D4, K4);
        pulse(D4, K4);
        repeat (199) @(posedge clk);
        #1;
        chk("pre_rst_cs2", 256'(cs2), 256'd0);
        chk("pre_rst_busy", 256'(busy), 256'd7);
        rst = 1'b1;
        #1;
        chk("abort_cs1", 256'(cs1), 256'd7);
        chk("abort_cs2", 256'(cs2), 256'd7);
        chk("abort_busy", 256'(busy), 256'd0);
        chk("abort_load_done", 256'(load_done), 256'd0);
        -> ev_clr;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        ndone = 0;
        repeat (400) begin
            @(posedge clk);
            #1 if (load_done != 3'b000) ndone++;
        end
        chk("no_done_after_abort", 256'(ndone), 256'd0);

        // Clean load after the abort sees the freshly reset core contents.
        push(D5, K5);
        pulse(D5, K5);
        wait_idle("e");
        repeat (20) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("hold_data_echo%0d", g), 256'(decho[g]), 256'({128{1'b1}}));
            chk($sformatf("hold_key_echo%0d", g), kecho[g], PRE_K256 >> (256 - 32 * (4 + 2 * g)));
        end

        -> ev_end;
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
